// File: rtl/fb_write_bridge.sv
// fb_write_bridge
//
// CPU-side responder for data-bus writes into the framebuffer window. Each
// accepted write is queued in a small FIFO and drained into the shared
// framebuffer BRAM write port on cycles the VGA renderer leaves free. A
// status word (overflow flag, FIFO level, drop count) can be polled by software.
//
// Build option:
//   FB_COALESCE_EN - when defined, a hit whose address matches the newest
//                    queued entry overwrites that entry's data instead of
//                    pushing a new one.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   A_data     in   [13:0] CPU data address
//   D_out      in   [15:0] CPU write data ([7:0] goes to the framebuffer)
//   w_en       in   CPU write strobe, one cycle per write
//   rwen_next  in   renderer drives the framebuffer write port next cycle
//   D_rd       out  [15:0] registered status read data
//   full       out  FIFO full
//   fb_A       out  [8:0] framebuffer write address
//   fb_D       out  [7:0] framebuffer write data
//   fb_wen     out  framebuffer write enable

module fb_write_bridge #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [4:0]  FB_WIN      = 5'h18,
    parameter logic [13:0] STATUS_ADDR = 14'h3200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [13:0] A_data,
    input  logic [15:0] D_out,
    input  logic        w_en,
    input  logic        rwen_next,
    output logic [15:0] D_rd,
    output logic        full,
    output logic [8:0]  fb_A,
    output logic [7:0]  fb_D,
    output logic        fb_wen
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Entry layout: {address[8:0], data[7:0]}
    logic [16:0]   mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drops_q, drops_d;

    logic          hit;
    logic          pop;
    logic          push;
    logic          drop;
    logic          coalesce;
    logic          status_clr;
    logic [4:0]    count_ext;
    logic [15:0]   status_word;

    // Bits of D_out that never reach the framebuffer or the control path.
    logic          unused_dout_bits;
    assign unused_dout_bits = ^D_out[14:8];

`ifdef FB_COALESCE_EN
    logic [PW-1:0] tail_ptr;
    assign tail_ptr = wr_ptr_q - PW'(1);
`endif

    always_comb begin
        hit        = w_en && (A_data[13:9] == FB_WIN);
        full       = (count_q == CW'(DEPTH));
        pop        = (count_q != '0) && !rwen_next;
`ifdef FB_COALESCE_EN
        // A lone entry that is leaving this cycle cannot absorb the write.
        coalesce   = hit && (count_q != '0) && (mem[tail_ptr][16:8] == A_data[8:0]) &&
                     !((count_q == CW'(1)) && pop);
`else
        coalesce   = 1'b0;
`endif
        // A full FIFO still accepts a write when the head leaves this cycle.
        push       = hit && !coalesce && (!full || pop);
        drop       = hit && !coalesce && full && !pop;
        status_clr = w_en && (A_data == STATUS_ADDR) && D_out[15];

        count_ext   = 5'(count_q);
        status_word = {overflow_q, 3'b000, count_ext[3:0], drops_q};
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drops_d    = drops_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drops_q != 8'hFF) begin
                drops_d = drops_q + 8'd1;
            end
        end

        // Status address lies outside the window, so clear and drop never coincide.
        if (status_clr) begin
            overflow_d = 1'b0;
            drops_d    = 8'h00;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drops_q    <= 8'h00;
            fb_wen     <= 1'b0;
            fb_A       <= 9'h000;
            fb_D       <= 8'h00;
            D_rd       <= 16'h0000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
            fb_wen     <= pop;
            if (pop) begin
                fb_A <= mem[rd_ptr_q][16:8];
                fb_D <= mem[rd_ptr_q][7:0];
            end
            D_rd <= (A_data == STATUS_ADDR) ? status_word : 16'h0000;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= {A_data[8:0], D_out[7:0]};
        end
`ifdef FB_COALESCE_EN
        else if (coalesce) begin
            mem[tail_ptr][7:0] <= D_out[7:0];
        end
`endif
    end

endmodule

// File: tb/tb_fb_write_bridge.sv
module tb_fb_write_bridge;

    localparam int unsigned DEPTH = 8;

    logic        clock;
    logic        reset;
    logic [13:0] A_data;
    logic [15:0] D_out;
    logic        w_en;
    logic        rwen_next;
    logic [15:0] D_rd;
    logic        full;
    logic [8:0]  fb_A;
    logic [7:0]  fb_D;
    logic        fb_wen;

    fb_write_bridge #(
        .DEPTH      (DEPTH),
        .FB_WIN     (5'h18),
        .STATUS_ADDR(14'h3200)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .A_data   (A_data),
        .D_out    (D_out),
        .w_en     (w_en),
        .rwen_next(rwen_next),
        .D_rd     (D_rd),
        .full     (full),
        .fb_A     (fb_A),
        .fb_D     (fb_D),
        .fb_wen   (fb_wen)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [16:0] q[$];
    logic        m_ov;
    logic [7:0]  m_drops;
    logic        exp_wen;
    logic [8:0]  exp_a;
    logic [7:0]  exp_d;
    logic [15:0] exp_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov    = 1'b0;
        m_drops = 8'h00;
        exp_wen = 1'b0;
        exp_a   = 9'h000;
        exp_d   = 8'h00;
        exp_rd  = 16'h0000;
    endtask

    // One bus cycle: drive at negedge, predict, check just after the edge.
    task automatic step(input logic we, input logic [13:0] a, input logic [15:0] d,
                        input logic rw);
        logic       hit, pop, is_full, coal;
        logic [7:0] cnt8;
        @(negedge clock);
        w_en = we; A_data = a; D_out = d; rwen_next = rw;

        cnt8    = 8'(q.size());
        hit     = we && (a[13:9] == 5'h18);
        pop     = (q.size() > 0) && !rw;
        is_full = (q.size() == DEPTH);
        exp_rd  = (a == 14'h3200) ? {m_ov, 3'b000, cnt8[3:0], m_drops} : 16'h0000;
        coal    = 1'b0;
`ifdef FB_COALESCE_EN
        coal = hit && (q.size() > 0) && (q[q.size()-1][16:8] == a[8:0]) &&
               !(q.size() == 1 && pop);
        if (coal) q[q.size()-1][7:0] = d[7:0];
`endif
        if (pop) begin
            exp_wen = 1'b1;
            exp_a   = q[0][16:8];
            exp_d   = q[0][7:0];
            void'(q.pop_front());
        end else begin
            exp_wen = 1'b0;
        end
        if (hit && !coal) begin
            if (!is_full || pop) begin
                q.push_back({a[8:0], d[7:0]});
            end else begin
                m_ov = 1'b1;
                if (m_drops != 8'hFF) m_drops = m_drops + 8'd1;
            end
        end
        if (we && a == 14'h3200 && d[15]) begin
            m_ov    = 1'b0;
            m_drops = 8'h00;
        end

        @(posedge clock);
        #1;
        check("fb_wen", fb_wen, exp_wen);
        check("fb_A", fb_A, exp_a);
        check("fb_D", fb_D, exp_d);
        check("full", full, q.size() == DEPTH);
        check("D_rd", D_rd, exp_rd);
        check("no_collide", fb_wen & rw, 1'b0);
    endtask

    initial begin
        int k;
        int thresh;
        logic [13:0] ra;
        logic        rwe;
        logic        rrw;
        logic [31:0] r;

        reset = 1'b1; w_en = 1'b0; A_data = 14'h0; D_out = 16'h0; rwen_next = 1'b0;
        model_reset();
        #12;
        check("rst_wen", fb_wen, 1'b0);
        check("rst_A", fb_A, 9'h000);
        check("rst_D", fb_D, 8'h00);
        check("rst_rd", D_rd, 16'h0000);
        check("rst_full", full, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Single write: two-cycle latency, one-cycle pulse
        step(1'b1, 14'h3005, 16'h00A5, 1'b0);
        check("t1_wen_early", fb_wen, 1'b0);
        step(1'b0, 14'h0000, 16'h0000, 1'b0);
        check("t1_wen", fb_wen, 1'b1);
        check("t1_A", fb_A, 9'h005);
        check("t1_D", fb_D, 8'hA5);
        step(1'b0, 14'h3200, 16'h0000, 1'b0);
        check("t1_wen_off", fb_wen, 1'b0);
        check("t1_status", D_rd, 16'h0000);

        // Stall, fill, overflow, then drain in order
        for (int i = 0; i < 8; i++) step(1'b1, 14'h3000 + 14'(i), 16'(8'h10 + i), 1'b1);
        check("t2_full", full, 1'b1);
        step(1'b1, 14'h3008, 16'h00EE, 1'b1);
        step(1'b0, 14'h3200, 16'h0000, 1'b1);
        check("t2_status", D_rd, 16'h8801);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 14'h0000, 16'h0000, 1'b0);
            check("t2_order", fb_A, 9'(i));
        end

        // Toggling renderer claims
        for (int i = 0; i < 4; i++) step(1'b1, 14'h3040 + 14'(i), 16'(i), 1'b1);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 14'h0000, 16'h0000, 1'(i % 2));
            if (fb_wen) begin
                check("t3_order", fb_A, 9'h040 + 9'(k));
                k++;
            end
        end
        check("t3_count", k, 4);

        // Full FIFO with same-cycle pop and hit
        for (int i = 0; i < 8; i++) step(1'b1, 14'h3080 + 14'(i), 16'(i), 1'b1);
        step(1'b1, 14'h3090, 16'h0055, 1'b0);
        check("t4_full", full, 1'b1);
        step(1'b0, 14'h3200, 16'h0000, 1'b1);
        check("t4_status", D_rd, 16'h8801);

        // Saturating drop counter, then clear
        for (int i = 0; i < 258; i++) step(1'b1, 14'h3100, 16'h0001, 1'b1);
        step(1'b0, 14'h3200, 16'h0000, 1'b1);
        check("t5_sat", D_rd, 16'h88FF);
        for (int i = 0; i < 9; i++) step(1'b0, 14'h0000, 16'h0000, 1'b0);
        step(1'b1, 14'h3200, 16'h8000, 1'b0);
        step(1'b0, 14'h3200, 16'h0000, 1'b0);
        check("t5_clear", D_rd, 16'h0000);

        // Same-address writes while stalled
        step(1'b1, 14'h3010, 16'h0011, 1'b1);
        step(1'b1, 14'h3010, 16'h0022, 1'b1);
        step(1'b0, 14'h3200, 16'h0000, 1'b1);
`ifdef FB_COALESCE_EN
        check("t6_cnt", D_rd[11:8], 4'd1);
        step(1'b0, 14'h0000, 16'h0000, 1'b0);
        check("t6_d0", fb_D, 8'h22);
        step(1'b0, 14'h0000, 16'h0000, 1'b0);
        check("t6_idle", fb_wen, 1'b0);
`else
        check("t6_cnt", D_rd[11:8], 4'd2);
        step(1'b0, 14'h0000, 16'h0000, 1'b0);
        check("t6_d0", fb_D, 8'h11);
        step(1'b0, 14'h0000, 16'h0000, 1'b0);
        check("t6_d1", fb_D, 8'h22);
        check("t6_wen1", fb_wen, 1'b1);
`endif

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) step(1'b1, 14'h3020 + 14'(i), 16'h0077, 1'b1);
        step(1'b0, 14'h0000, 16'h0000, 1'b0);
        check("t7_pre", fb_wen, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("t7_wen", fb_wen, 1'b0);
        check("t7_A", fb_A, 9'h000);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 14'h3200, 16'h0000, 1'b0);
        check("t7_status", D_rd, 16'h0000);

        // Randomized traffic against the model
        thresh = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) thresh = $urandom_range(0, 95);
            r   = $urandom_range(0, 99);
            rwe = (r < 60);
            r   = $urandom_range(0, 99);
            if (r < 40)      ra = {5'h18, 9'($urandom_range(0, 3))};
            else if (r < 70) ra = {5'h18, 9'($urandom)};
            else if (r < 85) ra = 14'h3200;
            else             ra = 14'($urandom);
            rrw = ($urandom_range(0, 99) < thresh);
            step(rwe, ra, 16'($urandom), rrw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
